gray_decode_tracker: RTL and testbench
======================================

Name: gray_decode_tracker

Overview:
Registered Gray-to-binary decoder, the receive side of the block that converts binary values to Gray code. Samples a Gray-coded position word and decodes it to binary. Classifies each new sample as a +1 step, a -1 step, no change, or an illegal jump. Maintains a signed position accumulator and a saturating error counter. Sits between a Gray-coded source (sensor or counter crossing logic) and downstream control logic.

Parameters:
WIDTH, 4, width of the Gray input and of the decoded binary output
POS_WIDTH, 16, width of the position accumulator (two's complement)
ERR_WIDTH, 8, width of the saturating error counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous reset, active-low; sampled on rising clk
gray_in  input  WIDTH  Gray-coded sample
in_valid  input  1  gray_in is valid this cycle
clr  input  1  synchronous clear of position and err_count
qbin  output  WIDTH  decoded binary value of the last accepted sample
out_valid  output  1  one-cycle pulse: qbin and step flags updated
step_up  output  1  pulse with out_valid: delta = +1
step_down  output  1  pulse with out_valid: delta = -1
step_err  output  1  pulse with out_valid: delta not in {0, +1, -1}
position  output  POS_WIDTH  accumulated steps
err_count  output  ERR_WIDTH  count of step_err events, saturating

Behaviour:
- Reset: reset is synchronous and active-low. It applies on a rising clk edge while reset==0. All outputs, pipeline registers, prev value and prev_valid flag are cleared to 0. An in-flight sample is discarded. Reset has priority over all other inputs.
- Stage 1: on a rising clk edge with in_valid==1, gray_in is captured into g_r and v1 is set. v1 otherwise clears.
- Stage 2, when v1==1:
  - Decode bin[WIDTH-1] = g_r[WIDTH-1], and bin[i] = bin[i+1] ^ g_r[i].
  - qbin <= bin; out_valid <= 1.
- Latency: 2 cycles. A sample with in_valid at edge N gives out_valid high after edge N+1, in the cycle following N+1.
- Throughput: one sample per cycle, back-to-back in_valid supported.
- Classification: delta = (bin - prev) mod 2^WIDTH.
  - 0: no flags.
  - 1: step_up.
  - 2^WIDTH-1: step_down.
  - Any other value: step_err.
  - Exactly one flag or none per out_valid. Flags are 0 whenever out_valid is 0.
- First sample after reset (prev_valid==0): no step flags. prev <= bin and prev_valid <= 1.
- After every decoded sample, including an error sample, prev <= bin (resynchronise on the new value).
- Wrap-around:
  - Input bin 15 -> 0 (WIDTH=4) is step_up; 0 -> 15 is step_down.
  - position wraps modulo 2^POS_WIDTH with no saturation.
- position: +1 on step_up, -1 on step_down, unchanged on error or no change.
- err_count: +1 on step_err, holds at 2^ERR_WIDTH-1.
- clr:
  - Zeroes position and err_count on the next edge.
  - If clr coincides with a step event, clr wins: the result is 0 and the step is not counted.
  - Step flags, qbin and prev are still updated normally.
  - clr does not affect the pipeline or prev_valid.
- Invalid input values: none exist. Every Gray word decodes to a legal binary value.

Optional Feature:
- Macro GRAY_DECODE_SYNC_EN.
- Defined:
  - gray_in passes through a 2-flop synchronizer before stage 1, for Gray values from another clock domain. in_valid is delayed by the same 2 flops so the two stay aligned.
  - Latency becomes 4 cycles.
  - Synchronizer flops are also cleared by reset.
- Not defined: no synchronizer; latency is 2 cycles as specified above.

Test Plan:
- Reset hold: drive reset=0 for 3 cycles with in_valid=1 -> all outputs 0, no out_valid; release, first sample 4'b0000 -> qbin=0, out_valid pulses, no step flags.
- Up count: Gray 0000,0001,0011,0010,0110 back-to-back -> qbin 0,1,2,3,4 on consecutive cycles, step_up on the last 4, position=4, err_count=0.
- Wrap: from bin 14 (1001) feed 1000 then 0000 then 1000 -> qbin 15 with step_up, 0 with step_up, 15 with step_down; position net +1.
- Illegal jump: prev bin 0 (0000), feed 0011 (bin 2) -> step_err=1, err_count=1, position unchanged; next 0010 (bin 3) -> step_up.
- Saturation/clear: 300 illegal jumps -> err_count holds at 255; assert clr together with a step_up -> position=0, err_count=0 next cycle, step_up still pulses.
- Reset mid-stream: assert reset one cycle after in_valid -> no out_valid for that sample; next sample after release treated as first (no step flags).

Source files
------------

// File: rtl/gray_decode_tracker.sv
// gray_decode_tracker: registered Gray-to-binary decoder with step tracking.
// Samples a Gray-coded word, decodes it to binary, classifies the change
// against the previous decoded value (+1 / -1 / none / illegal jump) and
// maintains a wrapping signed position and a saturating error counter.
//
// Optional build macro: GRAY_DECODE_SYNC_EN
//   When defined, gray_in and in_valid pass through a 2-flop synchronizer
//   ahead of stage 1 (latency 4 instead of 2).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-low
//   gray_in    Gray-coded sample (WIDTH)
//   in_valid   gray_in valid this cycle
//   clr        synchronous clear of position and err_count
//   qbin       decoded binary value of the last accepted sample (WIDTH)
//   out_valid  one-cycle pulse: qbin and step flags updated
//   step_up    pulse with out_valid: delta = +1
//   step_down  pulse with out_valid: delta = -1
//   step_err   pulse with out_valid: delta not in {0, +1, -1}
//   position   accumulated steps, two's complement, wrapping (POS_WIDTH)
//   err_count  saturating count of step_err events (ERR_WIDTH)
module gray_decode_tracker #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned POS_WIDTH = 16,
    parameter int unsigned ERR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 in_valid,
    input  logic                 clr,
    output logic [WIDTH-1:0]     qbin,
    output logic                 out_valid,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 step_err,
    output logic [POS_WIDTH-1:0] position,
    output logic [ERR_WIDTH-1:0] err_count
);

    logic [WIDTH-1:0]     s1_gray_c;
    logic                 s1_valid_c;
    logic [WIDTH-1:0]     g_r;
    logic                 v1;
    logic [WIDTH-1:0]     prev;
    logic                 prev_valid;
    logic [WIDTH-1:0]     bin_c;
    logic [WIDTH-1:0]     delta_c;
    logic                 up_c;
    logic                 dn_c;
    logic                 err_c;
    logic [POS_WIDTH-1:0] pos_next_c;
    logic [ERR_WIDTH-1:0] ec_next_c;

`ifdef GRAY_DECODE_SYNC_EN
    logic [WIDTH-1:0] sync1_g;
    logic [WIDTH-1:0] sync2_g;
    logic             sync1_v;
    logic             sync2_v;

    // 2-flop synchronizer; valid travels alongside the data to stay aligned
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_g <= '0;
            sync2_g <= '0;
            sync1_v <= 1'b0;
            sync2_v <= 1'b0;
        end else begin
            sync1_g <= gray_in;
            sync2_g <= sync1_g;
            sync1_v <= in_valid;
            sync2_v <= sync1_v;
        end
    end

    assign s1_gray_c  = sync2_g;
    assign s1_valid_c = sync2_v;
`else
    assign s1_gray_c  = gray_in;
    assign s1_valid_c = in_valid;
`endif

    // Stage 1: capture the sample
    always_ff @(posedge clk) begin
        if (!reset) begin
            g_r <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= s1_valid_c;
            if (s1_valid_c) begin
                g_r <= s1_gray_c;
            end
        end
    end

    // Decode, classify and compute next accumulator values
    always_comb begin
        bin_c      = '0;
        delta_c    = '0;
        up_c       = 1'b0;
        dn_c       = 1'b0;
        err_c      = 1'b0;
        pos_next_c = position;
        ec_next_c  = err_count;

        // bin[j] is the XOR of all Gray bits at or above j
        for (int i = 0; i < int'(WIDTH); i++) begin
            bin_c = bin_c ^ (g_r >> i);
        end

        delta_c = bin_c - prev;
        up_c    = v1 && prev_valid && (delta_c == WIDTH'(1));
        dn_c    = v1 && prev_valid && !up_c && (delta_c == {WIDTH{1'b1}});
        err_c   = v1 && prev_valid && (delta_c != '0) && !up_c && !dn_c;

        // clr overrides any step landing on the same edge
        if (clr) begin
            pos_next_c = '0;
        end else if (up_c) begin
            pos_next_c = position + POS_WIDTH'(1);
        end else if (dn_c) begin
            pos_next_c = position - POS_WIDTH'(1);
        end

        if (clr) begin
            ec_next_c = '0;
        end else if (err_c && (err_count != {ERR_WIDTH{1'b1}})) begin
            ec_next_c = err_count + ERR_WIDTH'(1);
        end
    end

    // Stage 2: register outputs and resynchronise prev on every decoded sample
    always_ff @(posedge clk) begin
        if (!reset) begin
            qbin       <= '0;
            out_valid  <= 1'b0;
            step_up    <= 1'b0;
            step_down  <= 1'b0;
            step_err   <= 1'b0;
            position   <= '0;
            err_count  <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            out_valid <= v1;
            step_up   <= up_c;
            step_down <= dn_c;
            step_err  <= err_c;
            position  <= pos_next_c;
            err_count <= ec_next_c;
            if (v1) begin
                qbin       <= bin_c;
                prev       <= bin_c;
                prev_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_decode_tracker.sv
// Self-checking bench for gray_decode_tracker: table-driven vectors plus
// hand-written sequences for saturation, clear and mid-stream reset.
module tb_gray_decode_tracker;

`ifdef GRAY_DECODE_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  gray_in;
    logic        in_valid;
    logic        clr;
    logic [3:0]  qbin;
    logic        out_valid;
    logic        step_up;
    logic        step_down;
    logic        step_err;
    logic [15:0] position;
    logic [7:0]  err_count;

    int total;
    int passed;

    typedef struct {
        logic [3:0] gray;
        logic       valid;
        logic [3:0] q;
        logic       ov;
        logic       up;
        logic       dn;
        logic       er;
        int         pos;
        int         ec;
    } vec_t;

    vec_t vecs[$];

    gray_decode_tracker #(
        .WIDTH(4),
        .POS_WIDTH(16),
        .ERR_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gray_in(gray_in),
        .in_valid(in_valid),
        .clr(clr),
        .qbin(qbin),
        .out_valid(out_valid),
        .step_up(step_up),
        .step_down(step_down),
        .step_err(step_err),
        .position(position),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic check_all(input string tag, input int q, input int ov, input int up,
                             input int dn, input int er, input int pos, input int ec);
        check({tag, ".qbin"}, int'(qbin), q);
        check({tag, ".out_valid"}, int'(out_valid), ov);
        check({tag, ".step_up"}, int'(step_up), up);
        check({tag, ".step_down"}, int'(step_down), dn);
        check({tag, ".step_err"}, int'(step_err), er);
        check({tag, ".position"}, int'(position), pos);
        check({tag, ".err_count"}, int'(err_count), ec);
    endtask

    task automatic add(input logic [3:0] g, input logic v, input logic [3:0] q, input logic ov,
                       input logic up, input logic dn, input logic er, input int pos, input int ec);
        vec_t t;
        t.gray = g; t.valid = v; t.q = q; t.ov = ov;
        t.up = up; t.dn = dn; t.er = er; t.pos = pos; t.ec = ec;
        vecs.push_back(t);
    endtask

    initial begin
        int n;
        int j;
        int ov_seen;
        total    = 0;
        passed   = 0;
        reset    = 1'b0;
        gray_in  = 4'b0101;
        in_valid = 1'b1;
        clr      = 1'b0;

        // Reset hold with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("reset_hold%0d", i), 0, 0, 0, 0, 0, 0, 0);
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        gray_in  = 4'b0000;

        //   gray     v     q      ov    up    dn    er    pos ec
        add(4'b0000, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 0,  0); // first sample
        add(4'b0001, 1'b1, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1,  0);
        add(4'b0011, 1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 2,  0);
        add(4'b0010, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 3,  0);
        add(4'b0110, 1'b1, 4'd4,  1'b1, 1'b1, 1'b0, 1'b0, 4,  0);
        add(4'b0000, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 4,  0); // idle: qbin holds
        add(4'b0111, 1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 1'b0, 5,  0);
        add(4'b0101, 1'b1, 4'd6,  1'b1, 1'b1, 1'b0, 1'b0, 6,  0);
        add(4'b0100, 1'b1, 4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 7,  0);
        add(4'b1100, 1'b1, 4'd8,  1'b1, 1'b1, 1'b0, 1'b0, 8,  0);
        add(4'b1101, 1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 1'b0, 9,  0);
        add(4'b1111, 1'b1, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 10, 0);
        add(4'b1110, 1'b1, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0, 11, 0);
        add(4'b1010, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 12, 0);
        add(4'b1011, 1'b1, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0, 13, 0);
        add(4'b1001, 1'b1, 4'd14, 1'b1, 1'b1, 1'b0, 1'b0, 14, 0);
        add(4'b1000, 1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 15, 0);
        add(4'b0000, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 16, 0); // 15 -> 0 wraps up
        add(4'b1000, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 15, 0); // 0 -> 15 wraps down
        add(4'b1000, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 15, 0); // no change
        add(4'b0000, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 16, 0);
        add(4'b0011, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 1'b1, 16, 1); // 0 -> 2 illegal
        add(4'b0010, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 17, 1); // resynced on 2
        add(4'b0000, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 17, 2); // 3 -> 0 illegal
        add(4'b1000, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 16, 2);
        add(4'b1100, 1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 16, 3); // 15 -> 8 illegal

        n = vecs.size();
        for (int k = 0; k < n + LAT - 1; k++) begin
            if (k < n) begin
                gray_in  = vecs[k].gray;
                in_valid = vecs[k].valid;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            j = k - (LAT - 1);
            if (j >= 0) begin
                check_all($sformatf("vec%0d", j), int'(vecs[j].q), int'(vecs[j].ov),
                          int'(vecs[j].up), int'(vecs[j].dn), int'(vecs[j].er),
                          vecs[j].pos, vecs[j].ec);
            end
        end

        // Saturation: 300 alternating 0 <-> 8 jumps starting from prev = 8
        for (int i = 0; i < 300; i++) begin
            gray_in  = (i % 2 == 0) ? 4'b0000 : 4'b1100;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        check_all("saturate", 8, 1, 0, 0, 1, 16, 255);

        // clr on the same edge as a step_up: clr wins, flags still pulse
        gray_in  = 4'b1101;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LAT - 2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all("clr_step", 9, 1, 1, 0, 0, 0, 0);

        // prev survived the clear
        gray_in  = 4'b1111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        check_all("after_clr", 10, 1, 1, 0, 0, 1, 0);

        // Reset one cycle after in_valid discards the sample
        gray_in  = 4'b1110;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        reset = 1'b1;
        check_all("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        ov_seen = 0;
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        check("mid_reset.no_out_valid", ov_seen, 0);

        // First sample after reset: bin 1 would be step_up if prev_valid survived
        gray_in  = 4'b0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        check_all("first_after_reset", 1, 1, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
